// File: rtl/fetch_wait_stage_if.sv
// fetch_wait_stage_if: fetch, bus-response and decode signals of the IF_wait stage
interface fetch_wait_stage_if;
    logic        ready_o;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        cancelled_i;
    logic        exc_i;
    logic        exc_miss_i;
    logic [4:0]  exccode_i;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic        cancel_i;
    modport master (
        output valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
               inst_data_ok, inst_rdata, ready_i, cancel_i,
        input  ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o
    );
    modport slave (
        input  valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
               inst_data_ok, inst_rdata, ready_i, cancel_i,
        output ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o
    );
endinterface

// File: rtl/fetch_wait_stage.sv
// fetch_wait_stage: in-order queue pairing accepted fetch requests with returned instruction words
module fetch_wait_stage #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               resetn,
    fetch_wait_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wptr, rptr, count;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [4:0]       code_q [DEPTH];
    logic [DEPTH-1:0] exc_q, miss_q, need_q, have_q, kill_q;
    logic [AW-1:0]    head, wslot, fill_idx, cand;
    logic             head_occ, head_done, push, pop, fill_hit;
    assign count     = wptr - rptr;
    assign head      = rptr[AW-1:0];
    assign wslot     = wptr[AW-1:0];
    assign head_occ  = count != '0;
    assign head_done = exc_q[head] || have_q[head];
    assign push      = bus.valid_i && bus.ready_o;
    // killed heads leave without ever being shown to decode
    assign pop       = (bus.valid_o && bus.ready_i) || (head_occ && head_done && kill_q[head]);
    assign bus.ready_o    = count != (AW+1)'(DEPTH);
    assign bus.valid_o    = head_occ && head_done && !kill_q[head] && !bus.cancel_i;
    assign bus.pc_o       = pc_q[head];
    assign bus.inst_o     = inst_q[head];
    assign bus.exc_o      = exc_q[head];
    assign bus.exc_miss_o = miss_q[head];
    assign bus.exccode_o  = code_q[head];
    // responses come back in request order, so the oldest waiting entry gets the word
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        cand     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            cand = head + AW'(k);
            if ((AW+1)'(k) < count && need_q[cand] && !have_q[cand]) begin
                fill_hit = 1'b1;
                fill_idx = cand;
            end
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr   <= '0;
            rptr   <= '0;
            exc_q  <= '0;
            miss_q <= '0;
            need_q <= '0;
            have_q <= '0;
            kill_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                code_q[i] <= '0;
            end
        end else begin
            if (bus.cancel_i) kill_q <= '1;
            if (push) begin
                pc_q[wslot]   <= bus.pc_i;
                inst_q[wslot] <= '0;
                code_q[wslot] <= bus.exccode_i;
                exc_q[wslot]  <= bus.exc_i;
                miss_q[wslot] <= bus.exc_miss_i;
                need_q[wslot] <= !bus.exc_i;
                have_q[wslot] <= 1'b0;
                kill_q[wslot] <= bus.cancelled_i || bus.cancel_i;
                wptr          <= wptr + 1'b1;
            end
            if (bus.inst_data_ok && fill_hit) begin
                inst_q[fill_idx] <= bus.inst_rdata;
                have_q[fill_idx] <= 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end
    assert property (@(posedge clk) disable iff (!resetn) bus.inst_data_ok |-> fill_hit);
endmodule

// File: tb/tb_fetch_wait_stage.sv
// tb_fetch_wait_stage: directed vectors for the IF_wait stage
module tb_fetch_wait_stage;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    fetch_wait_stage_if bus ();
    fetch_wait_stage #(.DEPTH(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic head(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'(v));
        if (v) begin
            check({tag, "_pc"}, bus.pc_o, pc);
            check({tag, "_inst"}, bus.inst_o, inst);
        end
    endtask
    // one clock: inputs for the coming edge, observed outputs reflect the edge just passed
    task automatic c(input logic v, input logic [31:0] pc, input logic dok, input logic [31:0] d,
                     input logic rdy, input logic cx);
        @(posedge clk);
        #1;
        bus.valid_i      = v;
        bus.pc_i         = pc;
        bus.inst_data_ok = dok;
        bus.inst_rdata   = d;
        bus.ready_i      = rdy;
        bus.cancel_i     = cx;
        bus.cancelled_i  = 1'b0;
        bus.exc_i        = 1'b0;
        bus.exc_miss_i   = 1'b0;
        bus.exccode_i    = '0;
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        resetn = 1'b0;
        bus.valid_i = 0; bus.pc_i = 0; bus.cancelled_i = 0; bus.exc_i = 0; bus.exc_miss_i = 0;
        bus.exccode_i = 0; bus.inst_data_ok = 0; bus.inst_rdata = 0; bus.ready_i = 1; bus.cancel_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid_o), 0);
        check("rst_ready", 32'(bus.ready_o), 1);
        check("rst_pc", bus.pc_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_exc", 32'(bus.exc_o), 0);
        check("rst_miss", 32'(bus.exc_miss_o), 0);
        check("rst_code", 32'(bus.exccode_o), 0);
        resetn = 1'b1;
        // reset with three requests outstanding; a response during reset is dropped
        c(1, 32'h100, 0, 0, 1, 0);
        c(1, 32'h104, 0, 0, 1, 0);
        c(1, 32'h108, 0, 0, 1, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t1_pend", 0, 0, 0);
        #2 resetn = 1'b0;
        #1;
        check("t1_rst_valid", 32'(bus.valid_o), 0);
        check("t1_rst_ready", 32'(bus.ready_o), 1);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.inst_data_ok = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check("t1_post_valid", 32'(bus.valid_o), 0);
        check("t1_post_ready", 32'(bus.ready_o), 1);
        check("t1_post_inst", bus.inst_o, 0);
        // back-to-back stream
        c(1, 32'hBFC0_0000, 0, 0, 1, 0);
        c(1, 32'hBFC0_0004, 1, 32'hA000_0000, 1, 0);
        head("t2_0", 0, 0, 0);
        c(1, 32'hBFC0_0008, 1, 32'hA000_0001, 1, 0);
        head("t2_1", 1, 32'hBFC0_0000, 32'hA000_0000);
        c(1, 32'hBFC0_000C, 1, 32'hA000_0002, 1, 0);
        head("t2_2", 1, 32'hBFC0_0004, 32'hA000_0001);
        c(0, 0, 1, 32'hA000_0003, 1, 0);
        head("t2_3", 1, 32'hBFC0_0008, 32'hA000_0002);
        c(0, 0, 0, 0, 1, 0);
        head("t2_4", 1, 32'hBFC0_000C, 32'hA000_0003);
        c(0, 0, 0, 0, 1, 0);
        head("t2_5", 0, 0, 0);
        check("t2_ready", 32'(bus.ready_o), 1);
        // back-pressure until full, then drain
        c(1, 32'h0000_1000, 0, 0, 0, 0);
        c(1, 32'h0000_1004, 1, 32'hB000_0000, 0, 0);
        c(1, 32'h0000_1008, 1, 32'hB000_0001, 0, 0);
        c(1, 32'h0000_100C, 1, 32'hB000_0002, 0, 0);
        check("t3_ready_cnt3", 32'(bus.ready_o), 1);
        c(0, 0, 1, 32'hB000_0003, 0, 0);
        check("t3_full_ready", 32'(bus.ready_o), 0);
        c(0, 0, 0, 0, 0, 0);
        check("t3_full_ready2", 32'(bus.ready_o), 0);
        head("t3_hold", 1, 32'h0000_1000, 32'hB000_0000);
        c(0, 0, 0, 0, 1, 0);
        head("t3_d0", 1, 32'h0000_1000, 32'hB000_0000);
        c(0, 0, 0, 0, 1, 0);
        head("t3_d1", 1, 32'h0000_1004, 32'hB000_0001);
        check("t3_ready_back", 32'(bus.ready_o), 1);
        c(0, 0, 0, 0, 1, 0);
        head("t3_d2", 1, 32'h0000_1008, 32'hB000_0002);
        c(0, 0, 0, 0, 1, 0);
        head("t3_d3", 1, 32'h0000_100C, 32'hB000_0003);
        c(0, 0, 0, 0, 1, 0);
        head("t3_empty", 0, 0, 0);
        // flush with responses still owed, then a post-flush fetch
        c(1, 32'h0000_2000, 0, 0, 1, 0);
        c(1, 32'h0000_2004, 0, 0, 1, 0);
        c(1, 32'h0000_2008, 0, 0, 1, 0);
        c(0, 0, 0, 0, 1, 1);
        head("t4_cx", 0, 0, 0);
        c(1, 32'h8000_0180, 0, 0, 1, 0);
        head("t4_a", 0, 0, 0);
        c(0, 0, 1, 32'hC000_0000, 1, 0);
        head("t4_b", 0, 0, 0);
        c(0, 0, 1, 32'hC000_0001, 1, 0);
        head("t4_c", 0, 0, 0);
        c(0, 0, 1, 32'hC000_0002, 1, 0);
        head("t4_d", 0, 0, 0);
        c(0, 0, 1, 32'hC000_0180, 1, 0);
        head("t4_e", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t4_post", 1, 32'h8000_0180, 32'hC000_0180);
        c(0, 0, 0, 0, 1, 0);
        head("t4_done", 0, 0, 0);
        // instruction then address-error entry behind it
        c(1, 32'hBFC0_0000, 0, 0, 1, 0);
        c(1, 32'h0000_0001, 1, 32'h2400_0001, 1, 0);
        bus.exc_i = 1'b1;
        bus.exccode_i = EXC_ADEL;
        head("t5_wait", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t5_inst", 1, 32'hBFC0_0000, 32'h2400_0001);
        check("t5_inst_exc", 32'(bus.exc_o), 0);
        c(0, 0, 0, 0, 1, 0);
        head("t5_exc", 1, 32'h0000_0001, 32'h0);
        check("t5_exc_o", 32'(bus.exc_o), 1);
        check("t5_code", 32'(bus.exccode_o), 32'(EXC_ADEL));
        check("t5_miss", 32'(bus.exc_miss_o), 0);
        c(0, 0, 0, 0, 1, 0);
        head("t5_done", 0, 0, 0);
        // lone TLB refill exception is visible one cycle after push
        c(1, 32'h0000_3000, 0, 0, 1, 0);
        bus.exc_i = 1'b1;
        bus.exc_miss_i = 1'b1;
        bus.exccode_i = EXC_TLBL;
        c(0, 0, 0, 0, 1, 0);
        head("t5b_exc", 1, 32'h0000_3000, 32'h0);
        check("t5b_miss", 32'(bus.exc_miss_o), 1);
        check("t5b_code", 32'(bus.exccode_o), 32'(EXC_TLBL));
        c(0, 0, 0, 0, 1, 0);
        head("t5b_done", 0, 0, 0);
        // entry cancelled in fetch drains silently once its data returns
        c(1, 32'h0000_4000, 0, 0, 1, 0);
        bus.cancelled_i = 1'b1;
        c(0, 0, 0, 0, 1, 0);
        head("t6_a", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t6_b", 0, 0, 0);
        c(0, 0, 1, 32'hD000_0000, 1, 0);
        head("t6_c", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t6_filled", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t6_drained", 0, 0, 0);
        check("t6_ready", 32'(bus.ready_o), 1);
        c(1, 32'h0000_5000, 0, 0, 1, 0);
        c(0, 0, 1, 32'hD000_5000, 1, 0);
        head("t6_r_wait", 0, 0, 0);
        c(1, 32'h0000_6000, 0, 0, 1, 0);
        head("t6_r", 1, 32'h0000_5000, 32'hD000_5000);
        c(0, 0, 1, 32'hD000_6000, 1, 0);
        head("t6_t_wait", 0, 0, 0);
        // flush while a complete head is present suppresses it immediately
        c(0, 0, 0, 0, 1, 1);
        head("t6_cx_same", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t6_cx_killed", 0, 0, 0);
        c(0, 0, 0, 0, 1, 0);
        head("t6_cx_empty", 0, 0, 0);
        check("t6_cx_ready", 32'(bus.ready_o), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
